// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
// The operand-select encoding and the scoreboard entry format live here.
package hazard_pkg;

  localparam int unsigned SB_RD_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               wr;
    logic               ld;
  } sb_entry_t;

  localparam sb_entry_t NOP_ENTRY = '{valid: 1'b0, rd: '0, wr: 1'b0, ld: 1'b0};

endpackage

// File: rtl/hz_src_match.sv
// Matches one ID source operand against the EX and MEM scoreboard entries
// and picks the nearest producer as the forward source.
module hz_src_match
  import hazard_pkg::*;
(
  input  logic [SB_RD_W-1:0] rs,
  input  logic               used,
  input  sb_entry_t          ex_q,
  input  sb_entry_t          mem_q,
  output logic               hit_ex,
  output logic               hit_mem,
  output fwd_sel_t           sel
);

  // x0 is hardwired to zero, so it never matches a producer
  function automatic logic entry_hit(sb_entry_t e, logic [SB_RD_W-1:0] a, logic u);
    return u && (a != '0) && e.valid && e.wr && (e.rd == a);
  endfunction

  assign hit_ex  = entry_hit(ex_q, rs, used);
  assign hit_mem = entry_hit(mem_q, rs, used);

  always_comb begin
    sel = FWD_RF;
    if (hit_ex) begin
      sel = FWD_MEM;
    end else if (hit_mem) begin
      sel = FWD_WB;
    end
  end

  // Load flag only matters to the load-use check in the parent
  logic unused_ld;
  assign unused_ld = ex_q.ld ^ mem_q.ld;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage core: scoreboard of
// in-flight destinations, registered forward selects, stall/flush controls.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter bit          FWD_EN     = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_wr,
  input  logic                  id_mem_rd,
  input  logic                  ex_br_taken,
  input  logic                  mem_busy,
  output logic                  stall_pc,
  output logic                  stall_if_id,
  output logic                  flush_if_id,
  output logic                  bubble_id_ex,
  output logic                  hold_back,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [CNT_W-1:0]      stall_cnt
);

  sb_entry_t        ex_q, mem_q, wb_q;
  fwd_sel_t         sel_a_q, sel_b_q;
  logic [CNT_W-1:0] cnt_q;

  logic     hit_ex_a, hit_mem_a, hit_ex_b, hit_mem_b;
  fwd_sel_t match_a, match_b, next_a, next_b;
  logic     raw_stall, cnt_inc;

  hz_src_match u_match_a (
    .rs      (SB_RD_W'(id_rs1)),
    .used    (id_rs1_used),
    .ex_q    (ex_q),
    .mem_q   (mem_q),
    .hit_ex  (hit_ex_a),
    .hit_mem (hit_mem_a),
    .sel     (match_a)
  );

  hz_src_match u_match_b (
    .rs      (SB_RD_W'(id_rs2)),
    .used    (id_rs2_used),
    .ex_q    (ex_q),
    .mem_q   (mem_q),
    .hit_ex  (hit_ex_b),
    .hit_mem (hit_mem_b),
    .sel     (match_b)
  );

  // Without forwarding every EX/MEM producer must drain; WB is write-through
  assign raw_stall = id_valid & (FWD_EN ? ((hit_ex_a | hit_ex_b) & ex_q.ld)
                                        : (hit_ex_a | hit_ex_b | hit_mem_a | hit_mem_b));
  assign next_a = FWD_EN ? match_a : FWD_RF;
  assign next_b = FWD_EN ? match_b : FWD_RF;

  // Priority: memory freeze, then redirect, then data hazard
  always_comb begin
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    flush_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    hold_back    = 1'b0;
    cnt_inc      = 1'b0;
    if (!rst_n) begin
      cnt_inc = 1'b0;
    end else if (mem_busy) begin
      stall_pc    = 1'b1;
      stall_if_id = 1'b1;
      hold_back   = 1'b1;
    end else if (ex_br_taken) begin
      flush_if_id  = 1'b1;
      bubble_id_ex = 1'b1;
    end else if (raw_stall) begin
      stall_pc     = 1'b1;
      stall_if_id  = 1'b1;
      bubble_id_ex = 1'b1;
      cnt_inc      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= NOP_ENTRY;
      mem_q   <= NOP_ENTRY;
      wb_q    <= NOP_ENTRY;
      sel_a_q <= FWD_RF;
      sel_b_q <= FWD_RF;
      cnt_q   <= '0;
    end else if (!mem_busy) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (bubble_id_ex || !id_valid) begin
        ex_q <= NOP_ENTRY;
      end else begin
        ex_q <= '{valid: 1'b1, rd: SB_RD_W'(id_rd), wr: id_reg_wr, ld: id_mem_rd};
      end
      sel_a_q <= bubble_id_ex ? FWD_RF : next_a;
      sel_b_q <= bubble_id_ex ? FWD_RF : next_b;
      if (cnt_inc && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign fwd_a_sel = sel_a_q;
  assign fwd_b_sel = sel_b_q;
  assign stall_cnt = cnt_q;

  // WB entry is tracked for visibility only; the register file writes through
  logic unused_wb;
  assign unused_wb = ^wb_q;

endmodule
